// File: rtl/mem_bus_arbiter.sv
// Arbitrates the instruction-fetch and data ports onto one memory bus. Each access
// goes to internal memory (single cycle) or external memory (EXT_WAIT extra cycles).
module mem_bus_arbiter #(
  parameter logic [31:0] EXT_BASE = 32'h0001_0000,
  parameter int unsigned EXT_WAIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        int_en,
  input  logic [31:0] int_rdata,
  output logic        ext_en,
  input  logic [31:0] ext_rdata,
  output logic        chipSelect,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_INT, S_EXT, S_RESP} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(EXT_WAIT);

  state_t      state, state_nxt;
  logic        last_d;     // 1 = data port won the previous grant
  logic        gnt_d;      // port owning the access in flight
  logic        we_q;
  logic [3:0]  wait_cnt;

  logic        any_req, pick_d, pick_int, rd_capture;
  logic [31:0] pick_addr, rd_data;

  // NOTE: every signal gets a default first so no path through the block infers a latch.
  always_comb begin
    any_req    = if_req | d_req;
    pick_d     = d_req & (~if_req | ~last_d);
    pick_addr  = pick_d ? d_addr : if_addr;
    pick_int   = pick_addr < EXT_BASE;
    rd_data    = chipSelect ? int_rdata : ext_rdata;
    rd_capture = ~we_q & ((state == S_INT) | ((state == S_EXT) & (wait_cnt == 4'd0)));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = pick_int ? S_INT : S_EXT;
      S_INT:   state_nxt = S_RESP;
      S_EXT:   if (wait_cnt == 4'd0) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d     <= 1'b0;
      gnt_d      <= 1'b0;
      we_q       <= 1'b0;
      wait_cnt   <= 4'd0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      chipSelect <= 1'b1;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if (state == S_IDLE && any_req) begin
        mem_addr   <= pick_addr;
        mem_wdata  <= d_wdata;
        we_q       <= pick_d & d_we;
        gnt_d      <= pick_d;
        last_d     <= pick_d;
        chipSelect <= pick_int;
        wait_cnt   <= WAIT_LOAD;
      end
      if (state == S_EXT && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
      if (rd_capture) begin
        if (gnt_d) d_rdata  <= rd_data;
        else       if_rdata <= rd_data;
      end
    end
  end

  assign int_en = (state == S_INT);
  assign ext_en = (state == S_EXT);
  assign mem_we = we_q & (int_en | ext_en);
  assign busy   = (state != S_IDLE);
  assign if_ack = (state == S_RESP) & ~gnt_d;
  assign d_ack  = (state == S_RESP) & gnt_d;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the processor memory bus between the instruction-fetch port and the data port.
- Decodes each access to internal memory (single access cycle) or external memory (EXT_WAIT extra wait cycles).
- Drives chipSelect and the per-memory enables, and returns read data with a one-cycle ack pulse.
- Sits between the core's IF/MEM stages and the internal/external memory blocks. It replaces a static chipSelect mux with a sequenced, arbitrated access.

Parameters:
- EXT_BASE, 32'h0001_0000: byte addresses >= EXT_BASE go to external memory; addresses below go to internal memory.
- EXT_WAIT, 3: extra wait cycles per external access (legal 0..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  instruction read request; held high until if_ack.
- if_addr  in  32  instruction address; stable while if_req is high.
- if_rdata  out  32  instruction read data; valid when if_ack=1.
- if_ack  out  1  one-cycle completion pulse.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1=write, 0=read.
- d_addr  in  32  data address.
- d_wdata  in  32  write data.
- d_rdata  out  32  read data; valid when d_ack=1.
- d_ack  out  1  one-cycle completion pulse.
- mem_addr  out  32  address to both memories.
- mem_we  out  1  write strobe, qualified by the enables.
- mem_wdata  out  32  write data to both memories.
- int_en  out  1  internal memory access enable.
- int_rdata  in  32  internal read data; combinational, valid in the same cycle as int_en.
- ext_en  out  1  external memory access enable.
- ext_rdata  in  32  external read data; valid in the last ext_en cycle.
- chipSelect  out  1  1=internal selected, 0=external selected.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All acks, enables, mem_we, busy = 0.
  - mem_addr, mem_wdata, if_rdata, d_rdata = 0.
  - chipSelect=1.
  - last_grant=IF, so the data port wins the first conflict.
- FSM states: IDLE, INT, EXT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Only one request pending: grant that port.
  - Both pending: grant the port not equal to last_grant (alternating fairness under contention).
  - On the grant edge, register mem_addr, mem_we (d_we for data, 0 for IF), mem_wdata, the granted port, and chipSelect = (addr < EXT_BASE).
  - Next state: INT if chipSelect=1, else EXT. Update last_grant.
- INT:
  - Exactly one cycle with int_en=1.
  - On a read, capture int_rdata into the granted port's rdata register at the end of the cycle.
  - Next state: RESP.
- EXT:
  - ext_en=1 for EXT_WAIT+1 cycles, counted by a 4-bit counter loaded with EXT_WAIT on entry.
  - On a read, capture ext_rdata on the cycle the counter reads 0.
  - Next state: RESP.
- RESP:
  - One cycle; assert the granted port's ack (1-cycle pulse). No enable is asserted.
  - Next state: IDLE.
- Latency from request sampled in IDLE to ack: internal = 2 cycles; external = EXT_WAIT+2 cycles.
- One access in flight at a time. The ungranted port waits with its request held; it is not dropped.
- Writes: ack is pulsed, and the port's rdata register keeps its previous value.
- The rdata registers hold their value until the next read for that port.
- Address decode boundary: EXT_BASE-4 → internal; EXT_BASE → external; 32'hFFFF_FFFC → external.
- EXT_WAIT=0: EXT lasts one cycle, giving the same timing as internal.
- Reset mid-access: enables and busy drop immediately (async). No ack is issued, and the aborted request is not resumed.
- Requester rule: a request whose ack was pulsed must deassert req the cycle after ack. A req still high after that is treated as a new request.

Test Plan:
- Internal read: if_req, if_addr=32'h1000, int_rdata=32'hDEAD_BEEF → int_en high 1 cycle, chipSelect=1, if_ack 2 cycles after sample, if_rdata=32'hDEADBEEF.
- External read, EXT_WAIT=3: d_req, d_we=0, d_addr=32'h0001_0000, ext_rdata=32'h5000 → ext_en high 4 cycles, chipSelect=0, d_ack at cycle 5, d_rdata=32'h5000.
- Data write to 32'hFFFC: d_wdata=32'h3000 → mem_we=1 with int_en for 1 cycle, d_ack pulsed, d_rdata unchanged.
- Simultaneous if_req and d_req held for 3 back-to-back conflicts → grant order D, IF, D; each port's ack fires exactly once per access.
- Reset asserted in the 2nd EXT cycle → ext_en=0 and busy=0 immediately, no ack, chipSelect=1. After release, a new if_req to 32'h0 completes normally.
- Boundary: d_addr=32'h0000_FFFC → chipSelect=1; d_addr=32'h0001_0000 → chipSelect=0. With EXT_WAIT=0, the external ack latency is 2 cycles.
